jtag_host_driver: RTL and testbench

//  Host-side JTAG sequencer. Sits directly upstream of the jtag_blinky TAP:

---
 rtl/jtag_host_driver.sv | 220 ++++++++++++++++++++++
 tb/tb_jtag_host_driver.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_host_driver.sv
// Host-side JTAG sequencer: turns single-beat TAP_RESET / SHIFT_IR / SHIFT_DR
// commands into TCK/TMS/TDI sequences and returns the captured TDO bits.
module jtag_host_driver #(
    parameter int MAX_LEN = 32,
    parameter int DIV     = 2,
    localparam int LW     = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LW-1:0]      cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               rsp_err,
    output logic               busy,
    output logic               jtag_tck,
    output logic               jtag_tms,
    output logic               jtag_tdi,
    output logic               jtag_trst_n,
    input  logic               jtag_tdo
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CW = (DIV > 1) ? $clog2(2 * DIV) : 1;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_RSVD  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRST,
        ST_PRE,
        ST_SHIFT,
        ST_POST,
        ST_RESP
    } state_t;

    state_t             state_reg;
    logic [1:0]         op_reg;
    logic [LW-1:0]      len_reg;
    logic [MAX_LEN-1:0] data_reg;
    logic [LW-1:0]      bit_cnt_reg;
    logic [CW-1:0]      cnt_reg;
    logic               tck_reg;
    logic               tms_reg;
    logic               tdi_reg;
    logic               trst_n_reg;
    logic               busy_reg;
    logic               rsp_valid_reg;
    logic               rsp_err_reg;
    logic [MAX_LEN-1:0] rsp_data_reg;

    logic               cmd_err;
    logic               last_bit;
    state_t             state_next;
    logic [LW-1:0]      idx_next;
    logic               tms_next;
    logic               tdi_next;
    logic [LW-1:0]      pre_last;

    assign cmd_ready   = !busy_reg && !rsp_valid_reg;
    assign busy        = busy_reg;
    assign rsp_valid   = rsp_valid_reg;
    assign rsp_err     = rsp_err_reg;
    assign rsp_data    = rsp_data_reg;
    assign jtag_tck    = tck_reg;
    assign jtag_tms    = tms_reg;
    assign jtag_tdi    = tdi_reg;
    assign jtag_trst_n = trst_n_reg;

    // TAP_RESET ignores cmd_len; only shift ops have a meaningful length.
    assign cmd_err = (cmd_op == OP_RSVD) ||
                     ((cmd_op != OP_RESET) &&
                      ((cmd_len == '0) || (int'(cmd_len) > MAX_LEN)));

    always_comb begin
        pre_last = LW'(2);
        if (op_reg == OP_RESET) begin
            pre_last = LW'(5);
        end else if (op_reg == OP_IR) begin
            pre_last = LW'(3);
        end
    end

    // Work out which TCK bit comes next and what TMS/TDI it needs.
    always_comb begin
        last_bit = 1'b1;
        case (state_reg)
            ST_PRE:   last_bit = (bit_cnt_reg == pre_last);
            ST_SHIFT: last_bit = (bit_cnt_reg == len_reg - LW'(1));
            ST_POST:  last_bit = (bit_cnt_reg == LW'(1));
            default:  last_bit = 1'b1;
        endcase

        state_next = state_reg;
        idx_next   = bit_cnt_reg + LW'(1);
        if (last_bit) begin
            idx_next = '0;
            case (state_reg)
                ST_PRE:   state_next = (op_reg == OP_RESET) ? ST_RESP : ST_SHIFT;
                ST_SHIFT: state_next = ST_POST;
                default:  state_next = ST_RESP;
            endcase
        end

        tms_next = 1'b0;
        tdi_next = 1'b0;
        case (state_next)
            ST_PRE: begin
                if (op_reg == OP_RESET) begin
                    tms_next = (idx_next < LW'(5));
                end else if (op_reg == OP_IR) begin
                    tms_next = (idx_next < LW'(2));
                end else begin
                    tms_next = (idx_next == '0);
                end
            end
            ST_SHIFT: begin
                tms_next = (idx_next == len_reg - LW'(1));
                tdi_next = data_reg[idx_next[IW-1:0]];
            end
            ST_POST: tms_next = (idx_next == '0);
            default: tms_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            op_reg        <= OP_RESET;
            len_reg       <= '0;
            data_reg      <= '0;
            bit_cnt_reg   <= '0;
            cnt_reg       <= '0;
            tck_reg       <= 1'b0;
            tms_reg       <= 1'b1;
            tdi_reg       <= 1'b0;
            trst_n_reg    <= 1'b1;
            busy_reg      <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_data_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        op_reg       <= cmd_op;
                        len_reg      <= cmd_len;
                        data_reg     <= cmd_data;
                        bit_cnt_reg  <= '0;
                        cnt_reg      <= '0;
                        rsp_data_reg <= '0;
                        if (cmd_err) begin
                            state_reg     <= ST_RESP;
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= 1'b1;
                        end else begin
                            rsp_err_reg <= 1'b0;
                            busy_reg    <= 1'b1;
                            tms_reg     <= 1'b1;
                            tdi_reg     <= 1'b0;
                            if (cmd_op == OP_RESET) begin
                                state_reg  <= ST_TRST;
                                trst_n_reg <= 1'b0;
                            end else begin
                                state_reg <= ST_PRE;
                            end
                        end
                    end
                end
                ST_TRST: begin
                    if (cnt_reg == CW'(2 * DIV - 1)) begin
                        trst_n_reg <= 1'b1;
                        cnt_reg    <= '0;
                        state_reg  <= ST_PRE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                ST_PRE, ST_SHIFT, ST_POST: begin
                    if (cnt_reg != CW'(DIV - 1)) begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end else begin
                        cnt_reg <= '0;
                        if (!tck_reg) begin
                            tck_reg <= 1'b1;
                            if (state_reg == ST_SHIFT) begin
                                rsp_data_reg[bit_cnt_reg[IW-1:0]] <= jtag_tdo;
                            end
                        end else begin
                            // Falling TCK edge: present the next bit's TMS/TDI.
                            tck_reg     <= 1'b0;
                            tms_reg     <= tms_next;
                            tdi_reg     <= tdi_next;
                            bit_cnt_reg <= idx_next;
                            state_reg   <= state_next;
                            if (state_next == ST_RESP) begin
                                busy_reg      <= 1'b0;
                                rsp_valid_reg <= 1'b1;
                            end
                        end
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_host_driver.sv
// Directed bench for jtag_host_driver driving a behavioural TAP with an
// IDCODE (32'h1) and a 10-bit LED data register.
module tb_jtag_host_driver;

    localparam int MAX_LEN = 32;
    localparam int DIV     = 2;
    localparam int LW      = $clog2(MAX_LEN + 1);

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_DR    = 2'd2;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_op = '0;
    logic [LW-1:0]      cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_data = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [MAX_LEN-1:0] rsp_data;
    logic               rsp_err;
    logic               busy;
    logic               jtag_tck;
    logic               jtag_tms;
    logic               jtag_tdi;
    logic               jtag_trst_n;
    logic               jtag_tdo;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    jtag_host_driver #(.MAX_LEN(MAX_LEN), .DIV(DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_len     (cmd_len),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .jtag_tck    (jtag_tck),
        .jtag_tms    (jtag_tms),
        .jtag_tdi    (jtag_tdi),
        .jtag_trst_n (jtag_trst_n),
        .jtag_tdo    (jtag_tdo)
    );

    // Behavioural TAP: IR 4 bits (1=IDCODE, 2=LED, else bypass), capture-IR 4'b0001.
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR
    } tap_t;

    tap_t        tap_state = TLR;
    logic [3:0]  ir = 4'h1;
    logic [3:0]  ir_sr = 4'h0;
    logic [31:0] dr_sr = '0;
    logic [9:0]  leds = '0;
    logic        tap_tdo = 1'b0;

    assign jtag_tdo = tap_tdo;

    always @(posedge jtag_tck or negedge jtag_trst_n) begin
        if (!jtag_trst_n) begin
            tap_state <= TLR;
            ir        <= 4'h1;
        end else begin
            case (tap_state)
                TLR:     tap_state <= jtag_tms ? TLR    : RTI;
                RTI:     tap_state <= jtag_tms ? SEL_DR : RTI;
                SEL_DR:  tap_state <= jtag_tms ? SEL_IR : CAP_DR;
                CAP_DR:  tap_state <= jtag_tms ? EX1_DR : SH_DR;
                SH_DR:   tap_state <= jtag_tms ? EX1_DR : SH_DR;
                EX1_DR:  tap_state <= jtag_tms ? UPD_DR : PA_DR;
                PA_DR:   tap_state <= jtag_tms ? EX2_DR : PA_DR;
                EX2_DR:  tap_state <= jtag_tms ? UPD_DR : SH_DR;
                UPD_DR:  tap_state <= jtag_tms ? SEL_DR : RTI;
                SEL_IR:  tap_state <= jtag_tms ? TLR    : CAP_IR;
                CAP_IR:  tap_state <= jtag_tms ? EX1_IR : SH_IR;
                SH_IR:   tap_state <= jtag_tms ? EX1_IR : SH_IR;
                EX1_IR:  tap_state <= jtag_tms ? UPD_IR : PA_IR;
                PA_IR:   tap_state <= jtag_tms ? EX2_IR : PA_IR;
                EX2_IR:  tap_state <= jtag_tms ? UPD_IR : SH_IR;
                default: tap_state <= jtag_tms ? SEL_DR : RTI;
            endcase
            case (tap_state)
                TLR:    ir <= 4'h1;
                CAP_IR: ir_sr <= 4'b0001;
                SH_IR:  ir_sr <= {jtag_tdi, ir_sr[3:1]};
                UPD_IR: ir <= ir_sr;
                CAP_DR: dr_sr <= (ir == 4'h1) ? 32'h1 :
                                 (ir == 4'h2) ? {22'b0, leds} : 32'h0;
                SH_DR: begin
                    if (ir == 4'h1)      dr_sr <= {jtag_tdi, dr_sr[31:1]};
                    else if (ir == 4'h2) dr_sr[9:0] <= {jtag_tdi, dr_sr[9:1]};
                    else                 dr_sr[0] <= jtag_tdi;
                end
                UPD_DR: if (ir == 4'h2) leds <= dr_sr[9:0];
                default: ;
            endcase
        end
    end

    always @(negedge jtag_tck or negedge jtag_trst_n) begin
        if (!jtag_trst_n) tap_tdo <= 1'b0;
        else              tap_tdo <= (tap_state == SH_DR) ? dr_sr[0] :
                                     (tap_state == SH_IR) ? ir_sr[0] : 1'b0;
    end

    // Edge monitors; tasks take snapshots instead of clearing them.
    int         rise_cnt = 0;
    int         trst_low_cnt = 0;
    logic [7:0] tms_hist = '0;
    int         rise_base = 0;
    int         trst_base = 0;

    always @(posedge jtag_tck) begin
        rise_cnt <= rise_cnt + 1;
        tms_hist <= {tms_hist[6:0], jtag_tms};
    end

    always @(posedge clk) begin
        if (!jtag_trst_n) trst_low_cnt <= trst_low_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = 0x%08h", tag, got);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [LW-1:0] len, input logic [31:0] data);
        @(negedge clk);
        rise_base = rise_cnt;
        trst_base = trst_low_cnt;
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!rsp_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    task automatic wait_rsp(output logic [31:0] d, output logic e);
        wait_valid();
        d = rsp_data;
        e = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [LW-1:0] len;
    } err_vec_t;

    err_vec_t err_vecs[3] = '{'{OP_DR, 6'd0}, '{2'd3, 6'd8}, '{OP_IR, 6'd33}};

    initial begin
        #1ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [31:0] d;
        logic        e;
        logic [31:0] snap;
        int          stall_bad;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_tck",       32'(jtag_tck),    32'd0);
        check("rst_tms",       32'(jtag_tms),    32'd1);
        check("rst_tdi",       32'(jtag_tdi),    32'd0);
        check("rst_trst_n",    32'(jtag_trst_n), 32'd1);
        check("rst_busy",      32'(busy),        32'd0);
        check("rst_cmd_ready", 32'(cmd_ready),   32'd1);
        check("rst_rsp_valid", 32'(rsp_valid),   32'd0);
        check("rst_rsp_err",   32'(rsp_err),     32'd0);
        check("rst_rsp_data",  rsp_data,         32'd0);

        rise_base = rise_cnt;
        repeat (100) @(negedge clk);
        check("idle_tck_edges", 32'(rise_cnt - rise_base), 32'd0);
        check("idle_tms",       32'(jtag_tms),             32'd1);

        // TAP reset: trst 4 clk, TMS 1,1,1,1,1,0.
        issue(OP_RESET, '0, 32'h0);
        check("reset_busy",      32'(busy),      32'd1);
        check("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        wait_rsp(d, e);
        check("reset_rsp_data",  d,                               32'd0);
        check("reset_rsp_err",   32'(e),                          32'd0);
        check("reset_trst_clks", 32'(trst_low_cnt - trst_base),   32'd4);
        check("reset_tck_edges", 32'(rise_cnt - rise_base),       32'd6);
        check("reset_tms_seq",   32'(tms_hist[5:0]),              32'h3E);
        check("reset_tap_rti",   32'(tap_state),                  32'(RTI));
        check("reset_tms_idle",  32'(jtag_tms),                   32'd0);

        // IDCODE read: 32 + 5 TCK, TMS tail ...0,1,1,0.
        issue(OP_DR, 6'd32, 32'h0);
        wait_rsp(d, e);
        check("idcode_rsp_data",  d,                         32'h0000_0001);
        check("idcode_rsp_err",   32'(e),                    32'd0);
        check("idcode_tck_edges", 32'(rise_cnt - rise_base), 32'd37);
        check("idcode_tms_tail",  32'(tms_hist),             32'h06);

        // Select LED register; capture-IR pattern comes back.
        issue(OP_IR, 6'd4, 32'h2);
        wait_rsp(d, e);
        check("ir_rsp_data",  d,                         32'h1);
        check("ir_tck_edges", 32'(rise_cnt - rise_base), 32'd10);
        check("ir_value",     32'(ir),                   32'h2);

        issue(OP_DR, 6'd10, 32'h2A5);
        wait_rsp(d, e);
        check("led1_rsp_data",  d,                         32'h0);
        check("led1_tck_edges", 32'(rise_cnt - rise_base), 32'd15);
        check("led1_leds",      32'(leds),                 32'h2A5);

        issue(OP_DR, 6'd10, 32'h2A5);
        wait_rsp(d, e);
        check("led2_rsp_data", d,          32'h2A5);
        check("led2_rsp_err",  32'(e),     32'd0);
        check("led2_leds",     32'(leds),  32'h2A5);

        // Rejected commands: immediate error response, no pin activity.
        for (int i = 0; i < 3; i++) begin
            issue(err_vecs[i].op, err_vecs[i].len, 32'hFFFF_FFFF);
            check($sformatf("err%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
            check($sformatf("err%0d_busy", i),      32'(busy),      32'd0);
            wait_rsp(d, e);
            check($sformatf("err%0d_rsp_err", i),   32'(e),         32'd1);
            check($sformatf("err%0d_rsp_data", i),  d,              32'd0);
            check($sformatf("err%0d_tck_edges", i), 32'(rise_cnt - rise_base), 32'd0);
            check($sformatf("err%0d_trst", i),      32'(trst_low_cnt - trst_base), 32'd0);
        end

        // Response back-pressure for 20 clk.
        issue(OP_DR, 6'd10, 32'h155);
        wait_valid();
        snap = rsp_data;
        stall_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (rsp_data !== snap || rsp_valid !== 1'b1 || cmd_ready !== 1'b0) stall_bad++;
        end
        check("stall_violations", 32'(stall_bad), 32'd0);
        check("stall_rsp_data",   snap,           32'h2A5);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("ack_rsp_valid", 32'(rsp_valid), 32'd0);
        check("ack_cmd_ready", 32'(cmd_ready), 32'd1);
        check("stall_leds",    32'(leds),      32'h155);

        // Asynchronous reset in the middle of a shift.
        issue(OP_DR, 6'd32, 32'hFFFF_FFFF);
        repeat (40) @(negedge clk);
        check("midshift_busy", 32'(busy),     32'd1);
        check("midshift_tdi",  32'(jtag_tdi), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_tck",       32'(jtag_tck),    32'd0);
        check("arst_tms",       32'(jtag_tms),    32'd1);
        check("arst_tdi",       32'(jtag_tdi),    32'd0);
        check("arst_trst_n",    32'(jtag_trst_n), 32'd1);
        check("arst_busy",      32'(busy),        32'd0);
        check("arst_cmd_ready", 32'(cmd_ready),   32'd1);
        check("arst_rsp_valid", 32'(rsp_valid),   32'd0);
        check("arst_rsp_data",  rsp_data,         32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
